// File: rtl/idu_exu_pipe.sv
// Decode-to-execute pipeline register; optional 2-entry skid buffer under IDU_EXU_SKID_EN.
// Latency: one cycle from acceptance to out_valid_o; flush_i and async rst empty every entry.
// Backpressure: registered in_ready_o (state != TWO) with skid, else ~out_valid_o | out_ready_i.

`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 32
`endif
`ifndef INST_NOP
`define INST_NOP 32'h00000013
`endif

module idu_exu_pipe (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [31:0]               inst_i,
   input  logic [31:0]               dec_pc_i,
   input  logic [31:0]               dec_imm_i,
   input  logic [31:0]               rs1_rdata_i,
   input  logic [31:0]               rs2_rdata_i,
   input  logic [`DECINFO_WIDTH-1:0] dec_info_bus_i,
   input  logic [4:0]                rd_waddr_i,
   input  logic                      rd_we_i,
   input  logic                      flush_i,
   input  logic                      out_ready_i,
   output logic                      out_valid_o,
   output logic [31:0]               inst_o,
   output logic [31:0]               dec_pc_o,
   output logic [31:0]               dec_imm_o,
   output logic [31:0]               rs1_rdata_o,
   output logic [31:0]               rs2_rdata_o,
   output logic [`DECINFO_WIDTH-1:0] dec_info_bus_o,
   output logic [4:0]                rd_waddr_o,
   output logic                      rd_we_o
);

   typedef struct packed {
      logic [31:0]               inst;
      logic [31:0]               pc;
      logic [31:0]               imm;
      logic [31:0]               rs1;
      logic [31:0]               rs2;
      logic [`DECINFO_WIDTH-1:0] info;
      logic [4:0]                waddr;
      logic                      we;
   } payload_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   function automatic payload_t nop_payload();
      payload_t p;
      p      = '0;
      p.inst = `INST_NOP;
      return p;
   endfunction

   state_t   state;
   payload_t in_p;
   payload_t out_q;
   logic     out_vld_q;
   logic     xfer_in;
   logic     xfer_out;

   assign in_p = '{inst: inst_i, pc: dec_pc_i, imm: dec_imm_i, rs1: rs1_rdata_i,
                   rs2: rs2_rdata_i, info: dec_info_bus_i, waddr: rd_waddr_i, we: rd_we_i};

   assign xfer_in  = in_valid_i & in_ready_o & ~flush_i;
   assign xfer_out = out_vld_q & out_ready_i;

`ifdef IDU_EXU_SKID_EN
   payload_t skid_q;
   logic     in_rdy_q;

   assign in_ready_o = in_rdy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_EMPTY;
         out_vld_q <= 1'b0;
         in_rdy_q  <= 1'b1;
         out_q     <= nop_payload();
         skid_q    <= '0;
      end else if (flush_i) begin
         state     <= S_EMPTY;
         out_vld_q <= 1'b0;
         in_rdy_q  <= 1'b1;
         out_q     <= nop_payload();
      end else begin
         case (state)
            S_EMPTY: begin
               if (xfer_in) begin
                  out_q     <= in_p;
                  out_vld_q <= 1'b1;
                  state     <= S_ONE;
               end
            end
            S_ONE: begin
               if (xfer_in && xfer_out) begin
                  out_q <= in_p;
               end else if (xfer_in) begin
                  // Execute stalled: park the new entry so ready can stay registered.
                  skid_q   <= in_p;
                  in_rdy_q <= 1'b0;
                  state    <= S_TWO;
               end else if (xfer_out) begin
                  out_q     <= nop_payload();
                  out_vld_q <= 1'b0;
                  state     <= S_EMPTY;
               end
            end
            S_TWO: begin
               if (xfer_out) begin
                  out_q    <= skid_q;
                  in_rdy_q <= 1'b1;
                  state    <= S_ONE;
               end
            end
            default: begin
               state     <= S_EMPTY;
               out_vld_q <= 1'b0;
               in_rdy_q  <= 1'b1;
               out_q     <= nop_payload();
            end
         endcase
      end
   end
`else
   assign in_ready_o = ~out_vld_q | out_ready_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_EMPTY;
         out_vld_q <= 1'b0;
         out_q     <= nop_payload();
      end else if (flush_i) begin
         state     <= S_EMPTY;
         out_vld_q <= 1'b0;
         out_q     <= nop_payload();
      end else begin
         case (state)
            S_EMPTY: begin
               if (xfer_in) begin
                  out_q     <= in_p;
                  out_vld_q <= 1'b1;
                  state     <= S_ONE;
               end
            end
            S_ONE: begin
               // With a single entry, acceptance here implies the held one leaves.
               if (xfer_in) begin
                  out_q <= in_p;
               end else if (xfer_out) begin
                  out_q     <= nop_payload();
                  out_vld_q <= 1'b0;
                  state     <= S_EMPTY;
               end
            end
            default: begin
               state     <= S_EMPTY;
               out_vld_q <= 1'b0;
               out_q     <= nop_payload();
            end
         endcase
      end
   end
`endif

   assign out_valid_o    = out_vld_q;
   assign inst_o         = out_q.inst;
   assign dec_pc_o       = out_q.pc;
   assign dec_imm_o      = out_q.imm;
   assign rs1_rdata_o    = out_q.rs1;
   assign rs2_rdata_o    = out_q.rs2;
   assign dec_info_bus_o = out_q.info;
   assign rd_waddr_o     = out_q.waddr;
   assign rd_we_o        = out_q.we;

endmodule
